// File: rtl/sdram_arbiter_if.sv
// One requester port of sdram_arbiter: request/length/direction in, grant/done/err back.
interface sdram_arbiter_if;
    logic       req;
    logic       rw_n;
    logic [8:0] bytes;
    logic       grant;
    logic       done;
    logic       err;

    modport master (output req, rw_n, bytes, input  grant, done, err);
    modport slave  (input  req, rw_n, bytes, output grant, done, err);
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of sdram_ctrl; one transaction in flight at a time.
// Optional watchdog abort is built only when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_arbiter #(
    parameter int TIMEOUT = 4096
) (
    input  logic                  clk_100m,
    input  logic                  rst_n,
    sdram_arbiter_if.slave        port_a,
    sdram_arbiter_if.slave        port_b,
    input  logic                  sdram_init_done,
    input  logic                  sdram_wr_ack,
    input  logic                  sdram_rd_ack,
    output logic                  sdram_wr_req,
    output logic                  sdram_rd_req,
    output logic [8:0]            sdwr_bytes,
    output logic [8:0]            sdrd_bytes,
    output logic                  arb_busy,
    output logic                  arb_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        rw_n_q, rw_n_d;
    logic [8:0]  bytes_q, bytes_d;
    logic        grant_a_q, grant_a_d;
    logic        grant_b_q, grant_b_d;
    logic        done_a_q, done_a_d;
    logic        done_b_q, done_b_d;
    logic        wr_req_q, wr_req_d;
    logic        rd_req_q, rd_req_d;
    logic        busy_q, busy_d;

    logic        any_req_s;
    logic        win_b_s;
    logic        win_rw_n_s;
    logic [8:0]  win_bytes_s;
    logic        ack_match_s;
    logic        timeout_s;

    // Winner selection: a lone requester wins, otherwise the port that was not served last.
    always_comb begin
        any_req_s = port_a.req | port_b.req;
        if (port_a.req && port_b.req) begin
            win_b_s = (last_q == PORT_A);
        end else begin
            win_b_s = port_b.req;
        end
        win_rw_n_s  = win_b_s ? port_b.rw_n  : port_a.rw_n;
        win_bytes_s = win_b_s ? port_b.bytes : port_a.bytes;
        ack_match_s = rw_n_q ? sdram_wr_ack : sdram_rd_ack;
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_a_q, err_a_d;
    logic        err_b_q, err_b_d;
    logic        arb_err_q, arb_err_d;

    // Watchdog count: held at zero in IDLE so it starts from zero on every entry to ISSUE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_ISSUE || state_q == ST_ACK) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
        timeout_s = (state_q == ST_ISSUE || state_q == ST_ACK) && (cnt_q == TIMEOUT_LAST);
        err_a_d   = timeout_s && (sel_q == PORT_A);
        err_b_d   = timeout_s && (sel_q == PORT_B);
        arb_err_d = arb_err_q | timeout_s;
    end

    // Watchdog and error flag registers.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            cnt_q     <= 16'd0;
            err_a_q   <= 1'b0;
            err_b_q   <= 1'b0;
            arb_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_a_q   <= err_a_d;
            err_b_q   <= err_b_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign port_a.err = err_a_q;
    assign port_b.err = err_b_q;
    assign arb_err    = arb_err_q;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^TIMEOUT;
    assign timeout_s        = 1'b0;
    assign port_a.err       = 1'b0;
    assign port_b.err       = 1'b0;
    assign arb_err          = 1'b0;
`endif

    // Next-state and next-output logic; all outputs are registered from the *_d values.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        sel_d     = sel_q;
        rw_n_d    = rw_n_q;
        bytes_d   = bytes_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        wr_req_d  = 1'b0;
        rd_req_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sdram_init_done && any_req_s) begin
                    sel_d   = win_b_s;
                    rw_n_d  = win_rw_n_s;
                    bytes_d = win_bytes_s;
                    if (win_bytes_s == 9'd0) begin
                        // Empty transfer never touches the SDRAM.
                        state_d  = ST_DONE;
                        last_d   = win_b_s;
                        done_a_d = ~win_b_s;
                        done_b_d = win_b_s;
                    end else begin
                        state_d   = ST_ISSUE;
                        grant_a_d = ~win_b_s;
                        grant_b_d = win_b_s;
                        wr_req_d  = win_rw_n_s;
                        rd_req_d  = ~win_rw_n_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (timeout_s) begin
                    state_d  = ST_DONE;
                    last_d   = sel_q;
                    done_a_d = ~sel_q;
                    done_b_d = sel_q;
                end else if (ack_match_s) begin
                    state_d   = ST_ACK;
                    grant_a_d = ~sel_q;
                    grant_b_d = sel_q;
                end else begin
                    // Refresh may delay the ack arbitrarily; keep the request asserted.
                    state_d   = ST_ISSUE;
                    grant_a_d = ~sel_q;
                    grant_b_d = sel_q;
                    wr_req_d  = rw_n_q;
                    rd_req_d  = ~rw_n_q;
                end
            end

            ST_ACK: begin
                if (timeout_s || !ack_match_s) begin
                    state_d  = ST_DONE;
                    last_d   = sel_q;
                    done_a_d = ~sel_q;
                    done_b_d = sel_q;
                end else begin
                    state_d   = ST_ACK;
                    grant_a_d = ~sel_q;
                    grant_b_d = sel_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_100m) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_q    <= PORT_B;
            sel_q     <= PORT_A;
            rw_n_q    <= 1'b0;
            bytes_q   <= 9'd0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            wr_req_q  <= 1'b0;
            rd_req_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            rw_n_q    <= rw_n_d;
            bytes_q   <= bytes_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            wr_req_q  <= wr_req_d;
            rd_req_q  <= rd_req_d;
            busy_q    <= busy_d;
        end
    end

    assign port_a.grant = grant_a_q;
    assign port_b.grant = grant_b_q;
    assign port_a.done  = done_a_q;
    assign port_b.done  = done_b_q;
    assign sdram_wr_req = wr_req_q;
    assign sdram_rd_req = rd_req_q;
    assign sdwr_bytes   = bytes_q;
    assign sdrd_bytes   = bytes_q;
    assign arb_busy     = busy_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: directed requests push expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_sdram_arbiter;

    logic       clk_100m = 1'b0;
    logic       rst_n;
    logic       sdram_init_done;
    logic       sdram_wr_ack;
    logic       sdram_rd_ack;
    logic       sdram_wr_req;
    logic       sdram_rd_req;
    logic [8:0] sdwr_bytes;
    logic [8:0] sdrd_bytes;
    logic       arb_busy;
    logic       arb_err;

    sdram_arbiter_if port_a ();
    sdram_arbiter_if port_b ();

    sdram_arbiter #(.TIMEOUT(16)) dut (
        .clk_100m        (clk_100m),
        .rst_n           (rst_n),
        .port_a          (port_a),
        .port_b          (port_b),
        .sdram_init_done (sdram_init_done),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdwr_bytes      (sdwr_bytes),
        .sdrd_bytes      (sdrd_bytes),
        .arb_busy        (arb_busy),
        .arb_err         (arb_err)
    );

    always #5 clk_100m = ~clk_100m;

    typedef struct packed {
        logic       port;   // 0 = A, 1 = B
        logic       err;
        logic [1:0] kind;   // 0 = no SDRAM access, 1 = read, 2 = write
        logic [8:0] bytes;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   viol_grant = 0;
    int   viol_req = 0;
    int   viol_pulse = 0;

    bit   ctrl_en;
    int   ack_delay;
    int   ack_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {4'd0, port_a.grant, port_b.grant, port_a.done, port_b.done,
                port_a.err, port_b.err, sdram_wr_req, sdram_rd_req,
                sdwr_bytes, sdrd_bytes, arb_busy, arb_err};
    endfunction

    task automatic start_req(input logic p, input logic rw, input logic [8:0] b,
                             input logic push, input logic exp_err);
        exp_t e;
        if (push) begin
            e.port  = p;
            e.err   = exp_err;
            e.kind  = (b == 9'd0) ? 2'd0 : (rw ? 2'd2 : 2'd1);
            e.bytes = b;
            exp_q.push_back(e);
        end
        if (p) begin
            port_b.rw_n = rw; port_b.bytes = b; port_b.req = 1'b1;
        end else begin
            port_a.rw_n = rw; port_a.bytes = b; port_a.req = 1'b1;
        end
    endtask

    task automatic wait_done(input logic p);
        int n;
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!(p ? port_b.done : port_a.done) && n < 2000);
        if (n >= 2000) check(p ? "done_wait_b" : "done_wait_a", p ? port_b.done : port_a.done, 1);
    endtask

    task automatic drop_req(input logic p);
        @(posedge clk_100m); #1;
        if (p) port_b.req = 1'b0;
        else   port_a.req = 1'b0;
    endtask

    task automatic run_port(input logic p, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            wait_done(p);
            @(posedge clk_100m); #1;
            if (i == cnt - 1) begin
                if (p) port_b.req = 1'b0;
                else   port_a.req = 1'b0;
            end
        end
    endtask

    // Behavioural sdram_ctrl: ack rises ack_delay cycles after a request, stays for ack_len.
    initial begin
        int  m_phase;
        int  m_cnt;
        bit  m_wr;
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        m_phase = 0; m_cnt = 0; m_wr = 1'b0;
        forever begin
            @(posedge clk_100m); #1;
            if (!rst_n) begin
                sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; m_phase = 0;
            end else if (m_phase == 0) begin
                if (ctrl_en && (sdram_wr_req || sdram_rd_req)) begin
                    m_wr = sdram_wr_req; m_cnt = ack_delay; m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (m_cnt == 0) begin
                    if (m_wr) sdram_wr_ack = 1'b1;
                    else      sdram_rd_ack = 1'b1;
                    m_cnt = ack_len; m_phase = 2;
                end else begin
                    m_cnt--;
                end
            end else begin
                if (m_cnt == 0) begin
                    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; m_phase = 0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on every done pulse.
    initial begin
        logic [1:0] obs_kind;
        logic [8:0] obs_bytes;
        logic       prev_da, prev_db;
        exp_t       e;
        obs_kind = 2'd0; obs_bytes = 9'd0; prev_da = 1'b0; prev_db = 1'b0;
        forever begin
            @(negedge clk_100m);
            if (!rst_n) begin
                obs_kind = 2'd0; obs_bytes = 9'd0; prev_da = 1'b0; prev_db = 1'b0;
            end else begin
                if (port_a.grant && port_b.grant) viol_grant++;
                if (sdram_rd_req && sdram_wr_req) viol_req++;
                if ((port_a.done && prev_da) || (port_b.done && prev_db)) viol_pulse++;
                if (sdram_rd_req) begin
                    obs_kind = 2'd1; obs_bytes = sdrd_bytes;
                end else if (sdram_wr_req) begin
                    obs_kind = 2'd2; obs_bytes = sdwr_bytes;
                end
                if (port_a.done || port_b.done) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", {port_a.done, port_b.done}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        check("done_port", {port_a.done, port_b.done}, e.port ? 2'b01 : 2'b10);
                        check("done_err", {port_a.err, port_b.err},
                              e.err ? (e.port ? 2'b01 : 2'b10) : 2'b00);
                        check("sdram_kind", obs_kind, e.kind);
                        check("sdram_bytes", obs_bytes, e.bytes);
                        check("grant_low_in_done", {port_a.grant, port_b.grant}, 2'b00);
                    end
                    obs_kind = 2'd0; obs_bytes = 9'd0;
                end
                prev_da = port_a.done;
                prev_db = port_b.done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int   n;
        logic flag;
        rst_n = 1'b0; sdram_init_done = 1'b0;
        ctrl_en = 1'b1; ack_delay = 2; ack_len = 2;
        port_a.req = 1'b0; port_a.rw_n = 1'b0; port_a.bytes = 9'd0;
        port_b.req = 1'b0; port_b.rw_n = 1'b0; port_b.bytes = 9'd0;
        repeat (3) @(posedge clk_100m);
        @(negedge clk_100m);
        check("reset_outputs", out_vec(), 32'd0);
        @(posedge clk_100m); #1 rst_n = 1'b1;

        // No grant while the controller is still initialising.
        start_req(1'b0, 1'b0, 9'd17, 1'b1, 1'b0);
        flag = 1'b0;
        repeat (50) begin
            @(negedge clk_100m);
            if (port_a.grant || port_b.grant || sdram_rd_req || sdram_wr_req) flag = 1'b1;
        end
        check("no_grant_before_init", flag, 1'b0);
        @(posedge clk_100m); #1 sdram_init_done = 1'b1;
        @(posedge clk_100m);
        @(negedge clk_100m);
        check("grant_a_after_init", {port_a.grant, port_b.grant, sdram_rd_req, sdram_wr_req}, 4'b1010);
        wait_done(1'b0);
        drop_req(1'b0);

        // Port B write of 256 bytes with refresh-like ack latency.
        ack_delay = 5; ack_len = 3;
        start_req(1'b1, 1'b1, 9'd256, 1'b1, 1'b0);
        @(posedge clk_100m);
        @(negedge clk_100m);
        check("b_write_issue", {port_b.grant, sdram_wr_req, sdram_rd_req}, 3'b110);
        check("sdwr_bytes", sdwr_bytes, 9'd256);
        port_b.bytes = 9'd5; port_b.rw_n = 1'b0;
        n = 0;
        while (!sdram_wr_ack && n < 200) begin @(negedge clk_100m); n++; end
        check("wr_req_held_until_ack", {sdram_wr_req, sdwr_bytes}, {1'b1, 9'd256});
        @(negedge clk_100m);
        check("wr_req_drop_after_ack", {sdram_wr_req, port_b.grant}, 2'b01);
        n = 0;
        while (sdram_wr_ack && n < 200) begin @(negedge clk_100m); n++; end
        check("done_b_not_early", port_b.done, 1'b0);
        @(negedge clk_100m);
        check("done_b_after_ack_fall", {port_b.done, port_b.grant}, 2'b10);
        drop_req(1'b1);

        // Zero-length request completes without any SDRAM request or grant.
        start_req(1'b0, 1'b0, 9'd0, 1'b1, 1'b0);
        @(posedge clk_100m);
        @(negedge clk_100m);
        check("zero_len_done", {port_a.done, port_a.grant, sdram_rd_req, sdram_wr_req}, 4'b1000);
        drop_req(1'b0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        // Controller never acks: the watchdog aborts after TIMEOUT cycles.
        ctrl_en = 1'b0;
        start_req(1'b0, 1'b1, 9'd40, 1'b1, 1'b1);
        @(posedge clk_100m);
        @(negedge clk_100m);
        n = 0;
        while (sdram_wr_req && n < 100) begin n++; @(negedge clk_100m); end
        check("timeout_req_cycles", n, 16);
        check("timeout_done_err", {port_a.done, port_a.err, arb_err}, 3'b111);
        drop_req(1'b0);
        ctrl_en = 1'b1;
        repeat (5) @(negedge clk_100m);
        check("arb_err_sticky", arb_err, 1'b1);
        @(posedge clk_100m); #1;
`endif

        // Reset during ACK: everything clears and no done pulse appears.
        ack_delay = 1; ack_len = 20;
        start_req(1'b0, 1'b0, 9'd33, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk_100m);
            n++;
        end while (!(sdram_rd_ack && !sdram_rd_req && port_a.grant) && n < 100);
        check("reached_ack_state", {sdram_rd_ack, sdram_rd_req, port_a.grant}, 3'b101);
        @(posedge clk_100m); #1;
        rst_n = 1'b0; port_a.req = 1'b0;
        @(posedge clk_100m);
        @(negedge clk_100m);
        check("reset_mid_ack_outputs", out_vec(), 32'd0);
        @(posedge clk_100m); #1 rst_n = 1'b1;
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk_100m);
            if (port_a.done || port_b.done) flag = 1'b1;
        end
        check("no_done_after_reset", flag, 1'b0);
        check("arb_err_cleared", arb_err, 1'b0);

        // Both ports requesting from reset: grants alternate A, B, A, B, A, B.
        ack_delay = 1; ack_len = 2;
        @(posedge clk_100m); #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_req(1'b0, 1'b0, 9'd3, 1'b1, 1'b0);
            start_req(1'b1, 1'b1, 9'd7, 1'b1, 1'b0);
        end
        @(posedge clk_100m); #1 rst_n = 1'b1;
        fork
            run_port(1'b0, 3);
            run_port(1'b1, 3);
        join

        repeat (5) @(negedge clk_100m);
        check("no_dual_grant", viol_grant, 0);
        check("no_dual_sdram_req", viol_req, 0);
        check("done_single_cycle", viol_pulse, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
